ddr_rw_arbiter: RTL and testbench

Schedules AXI write and read bursts onto the single command port of the DDR2 controller's command sequencer, and gives the refresh timer priority access between bursts. Each of the AW and AR channels gets a one-entry holding register. One burst is in flight at a time. Arbitration prefers row hits, alternates write/read on ties, and a starvation counter bounds how long either side can be bypassed. The block sits between the AXI slave front end and the DDR2 command/timing engine.

---
 rtl/ddr_rw_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ddr_rw_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rw_arbiter.sv
// ddr_rw_arbiter: schedules AXI write/read bursts onto the DDR2 command
// sequencer port, one burst in flight at a time, with refresh taking
// priority between bursts.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no burst in flight; arbitrate refresh / write / read
// ISSUE   | cmd_valid high with a stable payload, waiting for cmd_ready
// WAIT    | command accepted, waiting for the cmd_done pulse
// REFRESH | ref_gnt high until ref_req is released
module ddr_rw_arbiter #(
    parameter int ADDR_WIDTH = 27,
    parameter int COL_BITS   = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_end,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic                  ref_req,
    output logic                  ref_gnt,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_we,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [7:0]            cmd_len,
    input  logic                  cmd_done,
    output logic                  busy
);

    localparam int         ROW_W      = ADDR_WIDTH - COL_BITS;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REFRESH} state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  wr_full;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_len;
    logic                  rd_full;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_len;
    logic [ROW_W-1:0]      last_row;
    logic                  last_we;
    logic [3:0]            wr_starve;
    logic [3:0]            rd_starve;

    logic                  grant_wr;
    logic                  grant_rd;
    logic                  wr_hit;
    logic                  rd_hit;
    logic                  cmd_fire;

    assign awready  = !wr_full;
    assign arready  = !rd_full;
    assign cmd_fire = cmd_valid && cmd_ready;
    assign wr_hit   = (wr_addr[ADDR_WIDTH-1:COL_BITS] == last_row);
    assign rd_hit   = (rd_addr[ADDR_WIDTH-1:COL_BITS] == last_row);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and grant selection: refresh, starvation, row hit, alternation
    always_comb begin
        state_nxt = state;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (init_end) begin
                    if (ref_req) begin
                        state_nxt = REFRESH;
                    end else if (wr_full && rd_full) begin
                        if (wr_starve == STARVE_LIM)      grant_wr = 1'b1;
                        else if (rd_starve == STARVE_LIM) grant_rd = 1'b1;
                        else if (wr_hit && !rd_hit)       grant_wr = 1'b1;
                        else if (rd_hit && !wr_hit)       grant_rd = 1'b1;
                        else if (!last_we)                grant_wr = 1'b1;
                        else                              grant_rd = 1'b1;
                        state_nxt = ISSUE;
                    end else if (wr_full) begin
                        grant_wr  = 1'b1;
                        state_nxt = ISSUE;
                    end else if (rd_full) begin
                        grant_rd  = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE:   if (cmd_ready) state_nxt = WAIT;
            WAIT:    if (cmd_done)  state_nxt = IDLE;
            REFRESH: if (!ref_req)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded straight from the state register
    always_comb begin
        cmd_valid = (state == ISSUE);
        ref_gnt   = (state == REFRESH);
        busy      = (state != IDLE);
    end

    // Holding registers, command payload, row history and starvation counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_full   <= 1'b0;
            wr_addr   <= '0;
            wr_len    <= '0;
            rd_full   <= 1'b0;
            rd_addr   <= '0;
            rd_len    <= '0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            last_row  <= '0;
            last_we   <= 1'b0;
            wr_starve <= '0;
            rd_starve <= '0;
        end else begin
            // awready is low while full, so capture and clear are exclusive
            if (awvalid && awready) begin
                wr_addr <= awaddr;
                wr_len  <= awlen;
                wr_full <= 1'b1;
            end else if (cmd_fire && cmd_we) begin
                wr_full <= 1'b0;
            end

            if (arvalid && arready) begin
                rd_addr <= araddr;
                rd_len  <= arlen;
                rd_full <= 1'b1;
            end else if (cmd_fire && !cmd_we) begin
                rd_full <= 1'b0;
            end

            if (grant_wr) begin
                cmd_we    <= 1'b1;
                cmd_addr  <= wr_addr;
                cmd_len   <= wr_len;
                wr_starve <= '0;
                if (rd_full && rd_starve < STARVE_LIM) rd_starve <= rd_starve + 4'd1;
            end else if (grant_rd) begin
                cmd_we    <= 1'b0;
                cmd_addr  <= rd_addr;
                cmd_len   <= rd_len;
                rd_starve <= '0;
                if (wr_full && wr_starve < STARVE_LIM) wr_starve <= wr_starve + 4'd1;
            end

            if (cmd_fire) begin
                last_row <= cmd_addr[ADDR_WIDTH-1:COL_BITS];
                last_we  <= cmd_we;
            end
        end
    end

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Scenario bench for ddr_rw_arbiter: expected commands are queued in grant
// order as stimulus is applied and popped when the arbiter issues them.
module tb_ddr_rw_arbiter;

    localparam int AW = 27;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } cmd_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          init_end  = 1'b1;
    logic          awvalid   = 1'b0;
    logic [AW-1:0] awaddr    = '0;
    logic [7:0]    awlen     = '0;
    logic          arvalid   = 1'b0;
    logic [AW-1:0] araddr    = '0;
    logic [7:0]    arlen     = '0;
    logic          ref_req   = 1'b0;
    logic          cmd_ready = 1'b1;
    logic          cmd_done  = 1'b0;
    logic          awready;
    logic          arready;
    logic          ref_gnt;
    logic          cmd_valid;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic          busy;

    int   n_checks = 0;
    int   n_pass   = 0;
    cmd_t exp_q[$];

    ddr_rw_arbiter #(.ADDR_WIDTH(AW), .COL_BITS(10), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .init_end  (init_end),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arlen     (arlen),
        .ref_req   (ref_req),
        .ref_gnt   (ref_gnt),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_done  (cmd_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic cmd_t mk(input logic we, input logic [AW-1:0] addr, input logic [7:0] len);
        cmd_t c;
        c.we   = we;
        c.addr = addr;
        c.len  = len;
        return c;
    endfunction

    // Present AW and/or AR for one rising edge; called and returns at a falling edge.
    task automatic capture(input bit dw, input logic [AW-1:0] wa, input logic [7:0] wl,
                           input bit dr, input logic [AW-1:0] ra, input logic [7:0] rl);
        if (dw) begin awvalid = 1'b1; awaddr = wa; awlen = wl; end
        if (dr) begin arvalid = 1'b1; araddr = ra; arlen = rl; end
        @(negedge clk);
        awvalid = 1'b0;
        arvalid = 1'b0;
    endtask

    // Wait (bounded) for cmd_valid, record payload, step past the handshake edge.
    task automatic get_cmd(output cmd_t c);
        c = 'x;
        for (int i = 0; i < 64; i++) begin
            if (cmd_valid === 1'b1) begin
                c = {cmd_we, cmd_addr, cmd_len};
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic pulse_done();
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [40:0] got;
        logic [40:0] want;
        want = {6'b000011, 35'd0};
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        got = {cmd_valid, cmd_we, ref_gnt, busy, awready, arready, cmd_addr, cmd_len};
        n_checks++;
        if (got !== want) $display("FAIL reset_values: got %h want %h", got, want);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_release: got cmd_valid=%b busy=%b want 0 0", cmd_valid, busy);
        else n_pass++;
    endtask

    task automatic test_single_write();
        cmd_t c, e;
        exp_q.push_back(mk(1'b1, 27'h10, 8'd8));
        capture(1'b1, 27'h10, 8'd8, 1'b0, '0, '0);
        n_checks++;
        if (awready !== 1'b0 || cmd_valid !== 1'b0)
            $display("FAIL sw_capture: got awready=%b cmd_valid=%b want 0 0", awready, cmd_valid);
        else n_pass++;
        @(negedge clk);
        c = {cmd_we, cmd_addr, cmd_len};
        e = exp_q.pop_front();
        n_checks++;
        if (cmd_valid !== 1'b1 || c !== e)
            $display("FAIL sw_issue: got valid=%b cmd=%h want valid=1 cmd=%h", cmd_valid, c, e);
        else n_pass++;
        n_checks++;
        if (awready !== 1'b0) $display("FAIL sw_awready_held: got %b want 0", awready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (cmd_valid !== 1'b0 || awready !== 1'b1 || busy !== 1'b1)
            $display("FAIL sw_accept: got valid=%b awready=%b busy=%b want 0 1 1", cmd_valid, awready, busy);
        else n_pass++;
        repeat (9) @(negedge clk);
        pulse_done();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL sw_done_idle: got busy=%b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_tie();
        cmd_t c, e;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(mk(1'b1, 27'h1000, 8'd3));
        exp_q.push_back(mk(1'b0, 27'h2000, 8'd5));
        capture(1'b1, 27'h1000, 8'd3, 1'b1, 27'h2000, 8'd5);
        get_cmd(c);
        e = exp_q.pop_front();
        n_checks++;
        if (c !== e) $display("FAIL tie1_first: got %h want %h", c, e);
        else n_pass++;
        repeat (2) @(negedge clk);
        pulse_done();
        n_checks++;
        if (cmd_valid !== 1'b0) $display("FAIL b2b_idle_cycle: got cmd_valid=%b want 0", cmd_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (cmd_valid !== 1'b1) $display("FAIL b2b_next_issue: got cmd_valid=%b want 1", cmd_valid);
        else n_pass++;
        get_cmd(c);
        e = exp_q.pop_front();
        n_checks++;
        if (c !== e) $display("FAIL tie1_second: got %h want %h", c, e);
        else n_pass++;
        pulse_done();
        // Last burst was a read, so the next tie goes to the write.
        exp_q.push_back(mk(1'b1, 27'h3000, 8'd1));
        capture(1'b1, 27'h3000, 8'd1, 1'b1, 27'h5000, 8'd2);
        get_cmd(c);
        e = exp_q.pop_front();
        n_checks++;
        if (c !== e) $display("FAIL tie2_write: got %h want %h", c, e);
        else n_pass++;
        // Refill the write side; after a write the tie goes to the read.
        capture(1'b1, 27'h7000, 8'd4, 1'b0, '0, '0);
        exp_q.push_back(mk(1'b0, 27'h5000, 8'd2));
        exp_q.push_back(mk(1'b1, 27'h7000, 8'd4));
        pulse_done();
        get_cmd(c);
        e = exp_q.pop_front();
        n_checks++;
        if (c !== e) $display("FAIL tie3_read: got %h want %h", c, e);
        else n_pass++;
        pulse_done();
        get_cmd(c);
        e = exp_q.pop_front();
        n_checks++;
        if (c !== e) $display("FAIL tie3_write: got %h want %h", c, e);
        else n_pass++;
        pulse_done();
    endtask

    task automatic test_row_hit();
        cmd_t c, e;
        exp_q.push_back(mk(1'b0, 27'h400, 8'd0));
        capture(1'b0, '0, '0, 1'b1, 27'h400, 8'd0);
        get_cmd(c);
        e = exp_q.pop_front();
        n_checks++;
        if (c !== e) $display("FAIL rh_setup: got %h want %h", c, e);
        else n_pass++;
        exp_q.push_back(mk(1'b0, 27'h410, 8'd6));
        exp_q.push_back(mk(1'b1, 27'h8000, 8'd7));
        capture(1'b1, 27'h8000, 8'd7, 1'b1, 27'h410, 8'd6);
        pulse_done();
        get_cmd(c);
        e = exp_q.pop_front();
        n_checks++;
        if (c !== e) $display("FAIL rh_read_hit: got %h want %h", c, e);
        else n_pass++;
        pulse_done();
        get_cmd(c);
        e = exp_q.pop_front();
        n_checks++;
        if (c !== e) $display("FAIL rh_write_after: got %h want %h", c, e);
        else n_pass++;
        pulse_done();
    endtask

    task automatic test_starvation();
        cmd_t c, e;
        logic [AW-1:0] ra;
        exp_q.push_back(mk(1'b0, 27'h400, 8'd1));
        capture(1'b0, '0, '0, 1'b1, 27'h400, 8'd1);
        get_cmd(c);
        e = exp_q.pop_front();
        n_checks++;
        if (c !== e) $display("FAIL st_setup: got %h want %h", c, e);
        else n_pass++;
        exp_q.push_back(mk(1'b0, 27'h404, 8'd1));
        capture(1'b1, 27'h20000, 8'd9, 1'b1, 27'h404, 8'd1);
        for (int k = 1; k <= 4; k++) begin
            pulse_done();
            get_cmd(c);
            e = exp_q.pop_front();
            n_checks++;
            if (c !== e) $display("FAIL st_read%0d: got %h want %h", k, c, e);
            else n_pass++;
            ra = 27'h404 + 27'(4 * k);
            if (k == 4) exp_q.push_back(mk(1'b1, 27'h20000, 8'd9));
            exp_q.push_back(mk(1'b0, ra, 8'd1));
            capture(1'b0, '0, '0, 1'b1, ra, 8'd1);
        end
        pulse_done();
        get_cmd(c);
        e = exp_q.pop_front();
        n_checks++;
        if (c !== e) $display("FAIL st_forced_write: got %h want %h", c, e);
        else n_pass++;
        n_checks++;
        if (dut.wr_starve !== 4'd0) $display("FAIL st_counter_clear: got %0d want 0", dut.wr_starve);
        else n_pass++;
        pulse_done();
        get_cmd(c);
        e = exp_q.pop_front();
        n_checks++;
        if (c !== e) $display("FAIL st_last_read: got %h want %h", c, e);
        else n_pass++;
        pulse_done();
    endtask

    task automatic test_refresh();
        cmd_t c, e;
        exp_q.push_back(mk(1'b0, 27'h50000, 8'd2));
        capture(1'b0, '0, '0, 1'b1, 27'h50000, 8'd2);
        get_cmd(c);
        e = exp_q.pop_front();
        n_checks++;
        if (c !== e) $display("FAIL rf_setup: got %h want %h", c, e);
        else n_pass++;
        ref_req = 1'b1;
        capture(1'b0, '0, '0, 1'b1, 27'h60000, 8'd3);
        repeat (2) @(negedge clk);
        n_checks++;
        if (ref_gnt !== 1'b0) $display("FAIL rf_during_wait: got ref_gnt=%b want 0", ref_gnt);
        else n_pass++;
        pulse_done();
        n_checks++;
        if (ref_gnt !== 1'b0 || cmd_valid !== 1'b0)
            $display("FAIL rf_after_done: got ref_gnt=%b cmd_valid=%b want 0 0", ref_gnt, cmd_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ref_gnt !== 1'b1) $display("FAIL rf_grant: got ref_gnt=%b want 1", ref_gnt);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ref_gnt !== 1'b1 || cmd_valid !== 1'b0)
            $display("FAIL rf_hold: got ref_gnt=%b cmd_valid=%b want 1 0", ref_gnt, cmd_valid);
        else n_pass++;
        ref_req = 1'b0;
        exp_q.push_back(mk(1'b0, 27'h60000, 8'd3));
        @(negedge clk);
        n_checks++;
        if (ref_gnt !== 1'b0 || cmd_valid !== 1'b0)
            $display("FAIL rf_release: got ref_gnt=%b cmd_valid=%b want 0 0", ref_gnt, cmd_valid);
        else n_pass++;
        @(negedge clk);
        c = {cmd_we, cmd_addr, cmd_len};
        e = exp_q.pop_front();
        n_checks++;
        if (cmd_valid !== 1'b1 || c !== e)
            $display("FAIL rf_pending_read: got valid=%b cmd=%h want valid=1 cmd=%h", cmd_valid, c, e);
        else n_pass++;
        @(negedge clk);
        pulse_done();
    endtask

    task automatic test_reset_init();
        cmd_t c, e;
        bit   bad;
        cmd_ready = 1'b0;
        exp_q.push_back(mk(1'b1, 27'h70000, 8'd5));
        capture(1'b1, 27'h70000, 8'd5, 1'b0, '0, '0);
        @(negedge clk);
        c = {cmd_we, cmd_addr, cmd_len};
        e = exp_q.pop_front();
        n_checks++;
        if (cmd_valid !== 1'b1 || c !== e)
            $display("FAIL ri_issue: got valid=%b cmd=%h want valid=1 cmd=%h", cmd_valid, c, e);
        else n_pass++;
        repeat (3) @(negedge clk);
        c = {cmd_we, cmd_addr, cmd_len};
        n_checks++;
        if (cmd_valid !== 1'b1 || c !== e)
            $display("FAIL ri_stable: got valid=%b cmd=%h want valid=1 cmd=%h", cmd_valid, c, e);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0 || awready !== 1'b1)
            $display("FAIL ri_async_reset: got valid=%b busy=%b awready=%b want 0 0 1", cmd_valid, busy, awready);
        else n_pass++;
        @(negedge clk);
        rst       = 1'b0;
        init_end  = 1'b0;
        cmd_ready = 1'b1;
        exp_q.push_back(mk(1'b1, 27'h1400, 8'd2));
        capture(1'b1, 27'h1400, 8'd2, 1'b0, '0, '0);
        n_checks++;
        if (awready !== 1'b0) $display("FAIL ri_capture_no_init: got awready=%b want 0", awready);
        else n_pass++;
        bad = 1'b0;
        repeat (5) begin
            if (cmd_valid !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (bad) $display("FAIL ri_no_grant: got cmd_valid=1 while init_end=0 want 0");
        else n_pass++;
        init_end = 1'b1;
        @(negedge clk);
        c = {cmd_we, cmd_addr, cmd_len};
        e = exp_q.pop_front();
        n_checks++;
        if (cmd_valid !== 1'b1 || c !== e)
            $display("FAIL ri_init_issue: got valid=%b cmd=%h want valid=1 cmd=%h", cmd_valid, c, e);
        else n_pass++;
        @(negedge clk);
        pulse_done();
        n_checks++;
        if (exp_q.size() != 0 || busy !== 1'b0)
            $display("FAIL sb_drained: got %0d queued busy=%b want 0 queued busy=0", exp_q.size(), busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_tie();
        test_row_hit();
        test_starvation();
        test_refresh();
        test_reset_init();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
